// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_sequencer
//  Purpose  : Owns the PC, addresses the async-read InstructionMemory and
//             captures each word into a one-entry IF/ID buffer with a
//             valid/ready handshake. Handles start/restart, redirect with
//             flush, halt on HALT_WORD and an out-of-range fetch fault.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_sequencer #(
  parameter int                 ADDR_W    = 16,
  parameter int                 INSTR_W   = 16,
  parameter int                 MEM_DEPTH = 1024,
  parameter logic [INSTR_W-1:0] HALT_WORD = 16'hFFFF,
  parameter logic [ADDR_W-1:0]  RESET_PC  = 16'h0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               busy,
  output logic               halted,
  output logic               fault,
  output logic [15:0]        fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  // One extra bit so MEM_DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_LIMIT = (ADDR_W+1)'(MEM_DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              accept;
  logic              pc_out_of_range;

  // Buffer can take a new word when empty or being drained this cycle.
  assign accept          = !if_valid || if_ready;
  assign pc_out_of_range = {1'b0, pc} >= DEPTH_LIMIT;
  assign imem_addr       = pc;
  assign busy            = (state == S_FETCH);

  // Fetch state machine with registered IF/ID buffer and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (redirect_valid) begin
            // Flush the buffer and spend one bubble cycle reloading the PC.
            pc       <= redirect_pc;
            if_valid <= 1'b0;
          end else if (accept) begin
            if (pc_out_of_range) begin
              state    <= S_FAULT;
              fault    <= 1'b1;
              if_valid <= 1'b0;
            end else if (imem_instr == HALT_WORD) begin
              // Halt word is never handed to decode; pc stays on it.
              state    <= S_HALT;
              halted   <= 1'b1;
              if_valid <= 1'b0;
            end else begin
              if_instr <= imem_instr;
              if_pc    <= pc;
              if_valid <= 1'b1;
              pc       <= pc + ADDR_W'(1);
              if (fetch_count != 16'hFFFF) begin
                fetch_count <= fetch_count + 16'd1;
              end
            end
          end
        end

        S_HALT, S_FAULT: begin
          if (start) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            halted      <= 1'b0;
            fault       <= 1'b0;
            fetch_count <= '0;
            if_valid    <= 1'b0;
          end else if (if_valid && if_ready) begin
            if_valid <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
